// File: rtl/rr_stream_mux.sv
// N-channel valid/ready stream mux with round-robin arbitration and a registered output beat.
// Optional packet lock (no interleaving of packets) is enabled by defining RR_STREAM_MUX_PKT_LOCK_EN.
module rr_stream_mux #(
  parameter int N = 4,
  parameter int W = 8,
  localparam int SRC_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [N-1:0]       s_valid,
  input  logic [N*W-1:0]     s_data,
  input  logic [N-1:0]       s_last,
  output logic [N-1:0]       s_ready,
  output logic               m_valid,
  output logic [W-1:0]       m_data,
  output logic               m_last,
  output logic [SRC_W-1:0]   m_src,
  input  logic               m_ready
);

  localparam logic [SRC_W-1:0] LAST_CH = SRC_W'(N - 1);

  logic [SRC_W-1:0] last_grant_r;
  logic [N-1:0]     cand_s;
  logic [N-1:0]     grant_s;
  logic [SRC_W-1:0] grant_idx_s;
  logic [SRC_W-1:0] scan_s;
  logic             grant_any_s;
  logic             load_en_s;
  logic [W-1:0]     sel_data_s;
  logic             sel_last_s;

`ifdef RR_STREAM_MUX_PKT_LOCK_EN
  logic             lock_r;
  logic [SRC_W-1:0] lock_ch_r;
`endif

  assign load_en_s = !m_valid || m_ready;
  assign s_ready   = grant_s & {N{load_en_s}};

  // Candidate set: while a packet is locked only its channel may compete.
  always_comb begin
    cand_s = s_valid;
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
    if (lock_r) begin
      for (int i = 0; i < N; i++) begin
        cand_s[i] = s_valid[i] && (lock_ch_r == SRC_W'(i));
      end
    end else begin
      cand_s = s_valid;
    end
`endif
  end

  // Round-robin search from last_grant+1; wrap is an explicit compare so non-power-of-two N works.
  always_comb begin
    grant_s     = {N{1'b0}};
    grant_idx_s = {SRC_W{1'b0}};
    grant_any_s = 1'b0;
    scan_s      = last_grant_r;
    for (int k = 0; k < N; k++) begin
      if (scan_s == LAST_CH) begin
        scan_s = {SRC_W{1'b0}};
      end else begin
        scan_s = scan_s + SRC_W'(1);
      end
      if (!grant_any_s && cand_s[scan_s]) begin
        grant_any_s = 1'b1;
        grant_idx_s = scan_s;
      end else begin
        grant_any_s = grant_any_s;
      end
    end
    if (grant_any_s) begin
      grant_s[grant_idx_s] = 1'b1;
    end else begin
      grant_s = {N{1'b0}};
    end
  end

  // Payload of the granted channel.
  always_comb begin
    sel_data_s = {W{1'b0}};
    sel_last_s = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx_s == SRC_W'(i)) begin
        sel_data_s = s_data[i*W +: W];
        sel_last_s = s_last[i];
      end else begin
        sel_data_s = sel_data_s;
        sel_last_s = sel_last_s;
      end
    end
  end

  // Output register, round-robin pointer and packet lock.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_valid      <= 1'b0;
      m_data       <= {W{1'b0}};
      m_last       <= 1'b0;
      m_src        <= {SRC_W{1'b0}};
      last_grant_r <= LAST_CH;
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
      lock_r       <= 1'b0;
      lock_ch_r    <= {SRC_W{1'b0}};
`endif
    end else if (load_en_s) begin
      if (grant_any_s) begin
        m_valid      <= 1'b1;
        m_data       <= sel_data_s;
        m_last       <= sel_last_s;
        m_src        <= grant_idx_s;
        last_grant_r <= grant_idx_s;
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
        lock_r       <= !sel_last_s;
        lock_ch_r    <= grant_idx_s;
`endif
      end else begin
        m_valid <= 1'b0;
      end
    end else begin
      m_valid <= m_valid;
    end
  end

endmodule

// File: tb/tb_rr_stream_mux.sv
// Directed self-checking bench for rr_stream_mux (N=4, W=8); sources are queue-driven and hold
// their beat until it is accepted. Expectations follow RR_STREAM_MUX_PKT_LOCK_EN when defined.
module tb_rr_stream_mux;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  s_valid;
  logic [31:0] s_data;
  logic [3:0]  s_last;
  logic [3:0]  s_ready;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_last;
  logic [1:0]  m_src;
  logic        m_ready;

  int n_checks = 0;
  int n_pass   = 0;

  logic [8:0]  srcq[4][$];
  logic [10:0] exp_q[$];

  rr_stream_mux #(.N(4), .W(8)) dut (
    .clk(clk), .rstn(rstn),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_src(m_src),
    .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] bt(input logic [1:0] src, input logic last, input logic [7:0] d);
    return {src, last, d};
  endfunction

  function automatic logic [10:0] obs();
    return {m_src, m_last, m_data};
  endfunction

  task automatic push(input int ch, input logic last, input logic [7:0] d);
    srcq[ch].push_back({last, d});
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (srcq[i].size() > 0) begin
        s_valid[i]       = 1'b1;
        s_data[i*8 +: 8] = srcq[i][0][7:0];
        s_last[i]        = srcq[i][0][8];
      end else begin
        s_valid[i]       = 1'b0;
        s_data[i*8 +: 8] = 8'h00;
        s_last[i]        = 1'b0;
      end
    end
  endtask

  // One clock: note which sources handshake, step past the edge, retire them, re-drive.
  task automatic tick();
    logic [3:0] fire;
    @(negedge clk);
    fire = s_valid & s_ready;
    check("ready_onehot_subset",
          {31'd0, ($countones(s_ready) <= 1) && ((s_ready & ~s_valid) == 4'b0000)}, 32'd1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (fire[i]) void'(srcq[i].pop_front());
    end
    drive();
  endtask

  task automatic play(input string tag);
    for (int k = 0; k < exp_q.size(); k++) begin
      tick();
      check($sformatf("%s_valid[%0d]", tag, k), {31'd0, m_valid}, 32'd1);
      check($sformatf("%s_beat[%0d]", tag, k), {21'd0, obs()}, {21'd0, exp_q[k]});
    end
  endtask

  task automatic expect_idle(input string tag);
    tick();
    check(tag, {31'd0, m_valid}, 32'd0);
  endtask

  initial begin
    rstn    = 1'b0;
    m_ready = 1'b1;
    s_valid = 4'b0000;
    s_data  = 32'd0;
    s_last  = 4'b0000;

    // Reset with every channel valid, then a full rotation with no bubbles.
    for (int i = 0; i < 4; i++) push(i, 1'b1, 8'hA0 + 8'(i));
    for (int i = 0; i < 4; i++) push(i, 1'b1, 8'hB0 + 8'(i));
    drive();
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_m_data", {24'd0, m_data}, 32'd0);
    check("rst_m_last", {31'd0, m_last}, 32'd0);
    check("rst_m_src", {30'd0, m_src}, 32'd0);
    rstn = 1'b1;
    exp_q = '{bt(2'd0, 1'b1, 8'hA0), bt(2'd1, 1'b1, 8'hA1), bt(2'd2, 1'b1, 8'hA2),
              bt(2'd3, 1'b1, 8'hA3), bt(2'd0, 1'b1, 8'hB0), bt(2'd1, 1'b1, 8'hB1),
              bt(2'd2, 1'b1, 8'hB2), bt(2'd3, 1'b1, 8'hB3)};
    play("rotate");
    expect_idle("rotate_drain");

    // Backpressure: output frozen, no ready, next beat one cycle after release.
    push(2, 1'b0, 8'h21);
    push(2, 1'b1, 8'h22);
    drive();
    tick();
    check("bp_first", {21'd0, obs()}, {21'd0, bt(2'd2, 1'b0, 8'h21)});
    m_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      #1;
      check($sformatf("bp_hold[%0d]", k), {20'd0, m_valid, obs()}, {20'd0, 1'b1, bt(2'd2, 1'b0, 8'h21)});
      check($sformatf("bp_ready[%0d]", k), {28'd0, s_ready}, 32'd0);
    end
    m_ready = 1'b1;
    exp_q = '{bt(2'd2, 1'b1, 8'h22)};
    play("bp_release");
    expect_idle("bp_drain");

    // Packet from ch1 competing with ch2 (pointer now at 2, so ch1 wins first).
    push(1, 1'b0, 8'h11);
    push(1, 1'b0, 8'h12);
    push(1, 1'b1, 8'h13);
    push(2, 1'b1, 8'h2A);
    drive();
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
    exp_q = '{bt(2'd1, 1'b0, 8'h11), bt(2'd1, 1'b0, 8'h12), bt(2'd1, 1'b1, 8'h13),
              bt(2'd2, 1'b1, 8'h2A)};
`else
    exp_q = '{bt(2'd1, 1'b0, 8'h11), bt(2'd2, 1'b1, 8'h2A), bt(2'd1, 1'b0, 8'h12),
              bt(2'd1, 1'b1, 8'h13)};
`endif
    play("pkt");
    expect_idle("pkt_drain");

    // Single active channel gets back-to-back grants.
    push(1, 1'b1, 8'h41);
    push(1, 1'b1, 8'h42);
    push(1, 1'b1, 8'h43);
    drive();
    exp_q = '{bt(2'd1, 1'b1, 8'h41), bt(2'd1, 1'b1, 8'h42), bt(2'd1, 1'b1, 8'h43)};
    play("single");

    // Sparse channels with wrap: bring the pointer to 3, then ch0 and ch3 alternate from ch0.
    push(3, 1'b1, 8'h30);
    drive();
    exp_q = '{bt(2'd3, 1'b1, 8'h30)};
    play("sparse_prep");
    push(0, 1'b1, 8'h01);
    push(0, 1'b1, 8'h02);
    push(3, 1'b1, 8'h31);
    drive();
    exp_q = '{bt(2'd0, 1'b1, 8'h01), bt(2'd3, 1'b1, 8'h31), bt(2'd0, 1'b1, 8'h02)};
    play("sparse");
    expect_idle("sparse_drain");

    // Reset after the first beat of a ch2 packet.
    push(2, 1'b0, 8'h51);
    push(2, 1'b0, 8'h52);
    push(2, 1'b1, 8'h53);
    drive();
    exp_q = '{bt(2'd2, 1'b0, 8'h51)};
    play("midrst_first");
    rstn = 1'b0;
    #1;
    check("midrst_m_valid", {31'd0, m_valid}, 32'd0);
    check("midrst_m_src", {30'd0, m_src}, 32'd0);
    for (int i = 0; i < 4; i++) srcq[i].delete();
    push(0, 1'b1, 8'h60);
    push(2, 1'b1, 8'h55);
    drive();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    exp_q = '{bt(2'd0, 1'b1, 8'h60), bt(2'd2, 1'b1, 8'h55)};
    play("midrst_after");
    expect_idle("midrst_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
